// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader.
// State encoding and default geometry live here.
package imem_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] FILL_DEF = 8'h00;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-wide program load port (valid/ready with start and last).
// The loader is the slave; the image source is the master.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              LD_START;
    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_LAST;
    logic              LD_READY;

    modport master (
        output LD_START,
        output LD_VALID,
        output LD_DATA,
        output LD_LAST,
        input  LD_READY
    );

    modport slave (
        input  LD_START,
        input  LD_VALID,
        input  LD_DATA,
        input  LD_LAST,
        output LD_READY
    );

endinterface

// File: rtl/imem_loader_ram.sv
// Instruction store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module imem_loader_ram
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a program image into instruction memory and
// holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(FILL_DEF)
) (
    input  logic              CLK,
    input  logic              CLB,
    imem_loader_if.slave      ld,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] INST,
    output logic              CORE_CLB,
    output logic              LD_DONE,
    output logic              LD_ERR,
    output logic [ADDR_W:0]   LD_COUNT
);

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic              accept;
    logic [DATA_W-1:0] rdata;

    // Ready is a pure state decode, so no path from LD_VALID.
    assign ld.LD_READY = (state == ST_LOAD);
    assign accept      = ld.LD_READY && ld.LD_VALID;
    assign INST        = (state == ST_RUN) ? rdata : FILL;

    always_ff @(posedge CLK or negedge CLB) begin
        if (!CLB) begin
            state    <= ST_IDLE;
            wptr     <= '0;
            LD_COUNT <= '0;
            CORE_CLB <= 1'b0;
            LD_DONE  <= 1'b0;
            LD_ERR   <= 1'b0;
        end else if (ld.LD_START) begin
            // Start wins over any same-edge accept or LAST.
            state    <= ST_LOAD;
            wptr     <= '0;
            LD_COUNT <= '0;
            CORE_CLB <= 1'b0;
            LD_DONE  <= 1'b0;
            LD_ERR   <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        wptr     <= wptr + PTR_ONE;
                        LD_COUNT <= LD_COUNT + CNT_ONE;
                        if (ld.LD_LAST) begin
                            state <= ST_RELEASE;
                        end else if (wptr == '1) begin
                            state  <= ST_ERR;
                            LD_ERR <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    state    <= ST_RUN;
                    CORE_CLB <= 1'b1;
                    LD_DONE  <= 1'b1;
                end
                ST_IDLE, ST_RUN, ST_ERR: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    imem_loader_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (CLK),
        .we    (accept),
        .waddr (wptr),
        .wdata (ld.LD_DATA),
        .raddr (PC),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Reference model: image byte array plus expected flags.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       clb = 1'b0;
    logic [7:0] pc  = 8'h00;
    logic [7:0] inst;
    logic       core_clb;
    logic       ld_done;
    logic       ld_err;
    logic [8:0] ld_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];

    imem_loader_if #(.DATA_W(8)) ifc ();

    imem_loader dut (
        .CLK      (clk),
        .CLB      (clb),
        .ld       (ifc),
        .PC       (pc),
        .INST     (inst),
        .CORE_CLB (core_clb),
        .LD_DONE  (ld_done),
        .LD_ERR   (ld_err),
        .LD_COUNT (ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag,
                            input bit rdy, input bit cclb,
                            input bit done, input bit err,
                            input int cnt);
        chk({tag, ".ready"}, 32'(ifc.LD_READY), 32'(rdy));
        chk({tag, ".core_clb"}, 32'(core_clb), 32'(cclb));
        chk({tag, ".done"}, 32'(ld_done), 32'(done));
        chk({tag, ".err"}, 32'(ld_err), 32'(err));
        chk({tag, ".count"}, 32'(ld_count), cnt);
    endtask

    task automatic rd_chk(input string tag, input int a);
        pc = 8'(a);
        @(negedge clk);
        chk(tag, 32'(inst), 32'(ref_mem[a]));
    endtask

    task automatic do_load(input logic [7:0] img[$],
                           input bit last_end,
                           input bit gaps);
        int n;
        n = img.size();
        ifc.LD_START = 1'b1;
        ifc.LD_VALID = 1'b0;
        tick();
        ifc.LD_START = 1'b0;
        chk_outs("start", 1, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                repeat (g) begin
                    ifc.LD_VALID = 1'b0;
                    ifc.LD_DATA  = 8'($urandom);
                    ifc.LD_LAST  = 1'($urandom);
                    tick();
                end
            end
            ifc.LD_VALID = 1'b1;
            ifc.LD_DATA  = img[i];
            ifc.LD_LAST  = last_end && (i == n - 1);
            tick();
            ref_mem[i] = img[i];
        end
        ifc.LD_VALID = 1'b0;
        ifc.LD_LAST  = 1'b0;
        if (last_end) begin
            chk_outs("release", 0, 0, 0, 0, n);
            chk("release.inst", 32'(inst), 0);
            tick();
            chk_outs("run", 0, 1, 1, 0, n);
            for (int a = 0; a < n; a++) begin
                rd_chk("run.inst", a);
            end
            tick();
        end else begin
            chk_outs("overflow", 0, 0, 0, 1, n);
            chk("overflow.inst", 32'(inst), 0);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] x;
        logic [7:0] b0;
        logic [7:0] b1;

        ifc.LD_START = 1'b0;
        ifc.LD_VALID = 1'b0;
        ifc.LD_DATA  = 8'h00;
        ifc.LD_LAST  = 1'b0;

        // reset then idle, bytes offered in IDLE ignored
        repeat (3) tick();
        chk_outs("in_reset", 0, 0, 0, 0, 0);
        clb = 1'b1;
        repeat (2) tick();
        chk_outs("idle", 0, 0, 0, 0, 0);
        chk("idle.inst", 32'(inst), 0);
        ifc.LD_VALID = 1'b1;
        ifc.LD_LAST  = 1'b1;
        repeat (3) begin
            ifc.LD_DATA = 8'($urandom);
            tick();
        end
        ifc.LD_VALID = 1'b0;
        ifc.LD_LAST  = 1'b0;
        chk_outs("idle_bytes", 0, 0, 0, 0, 0);

        // overflow: 256 bytes without LAST
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        do_load(q, 1'b0, 1'b0);
        ifc.LD_START = 1'b1;
        tick();
        ifc.LD_START = 1'b0;
        chk_outs("err_clear", 1, 0, 0, 0, 0);

        // normal load, then backpressured load of same image
        q = {8'hA1, 8'hB2, 8'hC3};
        do_load(q, 1'b1, 1'b0);
        do_load(q, 1'b1, 1'b1);

        // bytes offered in RUN are not written
        ifc.LD_VALID = 1'b1;
        repeat (4) begin
            ifc.LD_DATA = 8'($urandom);
            ifc.LD_LAST = 1'($urandom);
            tick();
        end
        ifc.LD_VALID = 1'b0;
        ifc.LD_LAST  = 1'b0;
        chk_outs("run_bytes", 0, 1, 1, 0, 3);
        rd_chk("run_bytes.pc3", 3);

        // reload during RUN
        q = {8'h11};
        do_load(q, 1'b1, 1'b0);

        // restart mid-load: start beats LAST on same edge
        ifc.LD_START = 1'b1;
        tick();
        ifc.LD_START = 1'b0;
        ifc.LD_VALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ifc.LD_DATA = 8'($urandom);
            tick();
            ref_mem[i] = ifc.LD_DATA;
        end
        x = 8'($urandom);
        ifc.LD_START = 1'b1;
        ifc.LD_DATA  = x;
        ifc.LD_LAST  = 1'b1;
        tick();
        ref_mem[2] = x;
        ifc.LD_START = 1'b0;
        ifc.LD_VALID = 1'b0;
        ifc.LD_LAST  = 1'b0;
        chk_outs("restart", 1, 0, 0, 0, 0);
        tick();
        chk_outs("restart_hold", 1, 0, 0, 0, 0);
        q = {8'($urandom), 8'($urandom)};
        do_load(q, 1'b1, 1'b0);
        tick();
        rd_chk("restart.old_ptr", 2);

        // random images with random gaps
        repeat (6) begin
            int n;
            n = int'($urandom_range(1, 24));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_load(q, 1'b1, 1'($urandom));
        end

        // reset mid-load after 2 of 4 bytes
        ifc.LD_START = 1'b1;
        tick();
        ifc.LD_START = 1'b0;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        ifc.LD_VALID = 1'b1;
        ifc.LD_DATA  = b0;
        tick();
        ref_mem[0] = b0;
        ifc.LD_DATA = b1;
        tick();
        ref_mem[1] = b1;
        ifc.LD_DATA = 8'($urandom);
        clb = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0);
        repeat (2) tick();
        clb = 1'b1;
        repeat (4) begin
            ifc.LD_DATA = 8'($urandom);
            ifc.LD_LAST = 1'($urandom);
            tick();
        end
        ifc.LD_VALID = 1'b0;
        ifc.LD_LAST  = 1'b0;
        chk_outs("post_rst", 0, 0, 0, 0, 0);
        chk("post_rst.inst", 32'(inst), 0);
        q = {8'h5A};
        do_load(q, 1'b1, 1'b0);
        rd_chk("post_rst.pc1", 1);
        rd_chk("post_rst.pc2", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
